branch_resolver: RTL

Decode-stage branch resolution unit sitting directly downstream of the branch prediction buffer. Compares the predicted direction and fetch PC against the resolved branch/jump outcome, drives the `miss` feedback the predictor trains on, and issues a one-cycle redirect with the corrected PC. After each redirect it runs a counted wrong-path flush, and it keeps saturating branch/miss performance counters.

---
 rtl/branch_resolver_if.sv | 33 +++
 rtl/branch_resolver.sv | 97 +++++++++
 2 files changed

// File: rtl/branch_resolver_if.sv
// Decode-stage branch resolution bus: Decode inputs toward the resolver and
// its mispredict/redirect/flush feedback and performance counters.
interface branch_resolver_if #(
   parameter int unsigned CNT_WIDTH = 32
);
   logic                 en_i;
   logic                 pred_taken_i;
   logic [31:0]          pred_pc_i;
   logic                 is_branch_d_i;
   logic                 is_jump_d_i;
   logic                 taken_d_i;
   logic [31:0]          pc_plus_4_d_i;
   logic [31:0]          target_d_i;
   logic                 cnt_clr_i;
   logic                 miss_o;
   logic                 redirect_o;
   logic [31:0]          pc_branch_o;
   logic                 flush_o;
   logic [CNT_WIDTH-1:0] branch_cnt_o;
   logic [CNT_WIDTH-1:0] miss_cnt_o;

   modport slave (
      input  en_i, pred_taken_i, pred_pc_i, is_branch_d_i, is_jump_d_i,
             taken_d_i, pc_plus_4_d_i, target_d_i, cnt_clr_i,
      output miss_o, redirect_o, pc_branch_o, flush_o, branch_cnt_o, miss_cnt_o
   );

   modport master (
      output en_i, pred_taken_i, pred_pc_i, is_branch_d_i, is_jump_d_i,
             taken_d_i, pc_plus_4_d_i, target_d_i, cnt_clr_i,
      input  miss_o, redirect_o, pc_branch_o, flush_o, branch_cnt_o, miss_cnt_o
   );
endinterface

// File: rtl/branch_resolver.sv
// Resolves Decode branches/jumps against the prediction, issues redirects,
// runs a counted wrong-path flush and keeps saturating branch/miss counters.
module branch_resolver #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_WIDTH    = 32
) (
   input logic              clk_i,
   input logic              rst_ni,
   branch_resolver_if.slave bus
);

   typedef enum logic {RUN, RECOVER} state_e;

   state_e               state_q;
   logic [3:0]           flush_cnt_q;
   logic                 flush_q;
   logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

   logic        valid;
   logic        actual_taken;
   logic        cond_branch;
   logic        miss;
   logic        redirect;
   logic [31:0] pc_branch;

   // A branch+jump encoding is treated purely as a jump: no miss, no counting.
   always_comb begin
      valid        = bus.en_i && (state_q == RUN);
      actual_taken = bus.is_jump_d_i || (bus.is_branch_d_i && bus.taken_d_i);
      pc_branch    = actual_taken ? bus.target_d_i : bus.pc_plus_4_d_i;
      cond_branch  = valid && bus.is_branch_d_i && !bus.is_jump_d_i;
      miss         = cond_branch && (bus.pred_taken_i != bus.taken_d_i);
      redirect     = valid && (bus.is_branch_d_i || bus.is_jump_d_i)
                     && (pc_branch != bus.pred_pc_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= RUN;
         flush_cnt_q <= '0;
         flush_q     <= 1'b0;
      end else if (bus.en_i) begin
         case (state_q)
            RUN: begin
               if (redirect) begin
                  state_q     <= RECOVER;
                  flush_cnt_q <= 4'(FLUSH_CYCLES);
                  flush_q     <= 1'b1;
               end
            end
            RECOVER: begin
               flush_cnt_q <= flush_cnt_q - 4'd1;
               if (flush_cnt_q == 4'd1) begin
                  state_q <= RUN;
                  flush_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= RUN;
               flush_cnt_q <= '0;
               flush_q     <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      branch_cnt_d = branch_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      if (bus.cnt_clr_i) begin
         branch_cnt_d = '0;
         miss_cnt_d   = '0;
      end else if (cond_branch) begin
         if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
         if (miss && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         branch_cnt_q <= '0;
         miss_cnt_q   <= '0;
      end else begin
         branch_cnt_q <= branch_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   assign bus.miss_o       = miss;
   assign bus.redirect_o   = redirect;
   assign bus.pc_branch_o  = pc_branch;
   assign bus.flush_o      = flush_q;
   assign bus.branch_cnt_o = branch_cnt_q;
   assign bus.miss_cnt_o   = miss_cnt_q;

endmodule
